// File: rtl/lut_scan.sv
// Serially loadable N-input truth table with single evaluation and exhaustive sweep.
// Define LUT_SCAN_ONES_EN to add the oOnes minterm counter output.
module lut_scan #(
  parameter int unsigned       N    = 4,
  parameter logic [2**N-1:0]   INIT = '0
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iLoad,
  input  logic         iBit,
  input  logic [N-1:0] iX,
  input  logic         iEval,
  input  logic         iStart,
  output logic         oY,
  output logic         oValid,
  output logic [N-1:0] oIdx,
  output logic         oBusy,
  output logic         oDone
`ifdef LUT_SCAN_ONES_EN
  ,
  output logic [N:0]   oOnes
`endif
);

  localparam int unsigned Size = 2**N;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [Size-1:0]   lut_q, lut_d;
  logic [N-1:0]      idx_q, idx_d;
  logic              y_q, y_d;
  logic [N-1:0]      yidx_q, yidx_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
`ifdef LUT_SCAN_ONES_EN
  logic [N:0]        ones_q, ones_d;
`endif

  always_comb begin
    state_d = state_q;
    lut_d   = lut_q;
    idx_d   = idx_q;
    y_d     = y_q;
    yidx_d  = yidx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef LUT_SCAN_ONES_EN
    ones_d  = ones_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Load beats start beats eval; losers are dropped, not queued.
        if (iLoad) begin
          lut_d = {iBit, lut_q[Size-1:1]};
        end else if (iStart) begin
          state_d = StScan;
          idx_d   = '0;
`ifdef LUT_SCAN_ONES_EN
          ones_d  = '0;
`endif
        end else if (iEval) begin
          y_d     = lut_q[iX];
          yidx_d  = iX;
          valid_d = 1'b1;
        end
      end
      StScan: begin
        y_d     = lut_q[idx_q];
        yidx_d  = idx_q;
        valid_d = 1'b1;
        idx_d   = idx_q + 1'b1;
`ifdef LUT_SCAN_ONES_EN
        if (lut_q[idx_q]) ones_d = ones_q + 1'b1;
`endif
        if (&idx_q) state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= StIdle;
      lut_q   <= INIT;
      idx_q   <= '0;
      y_q     <= 1'b0;
      yidx_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LUT_SCAN_ONES_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lut_q   <= lut_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      yidx_q  <= yidx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef LUT_SCAN_ONES_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign oY     = y_q;
  assign oValid = valid_q;
  assign oIdx   = yidx_q;
  assign oBusy  = (state_q != StIdle);
  assign oDone  = done_q;
`ifdef LUT_SCAN_ONES_EN
  assign oOnes  = ones_q;
`endif

endmodule

// File: tb/tb_lut_scan.sv
// Scoreboard bench for lut_scan (N=4): expected {y, idx} pushed at stimulus, popped on oValid.
module tb_lut_scan;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, load, bit_in, eval, start;
  logic [N-1:0] x;
  logic         y, valid, busy, done;
  logic [N-1:0] idx;
`ifdef LUT_SCAN_ONES_EN
  logic [N:0]   ones;
`endif

  int tests = 0;
  int fails = 0;
  int valid_count = 0;
  logic [15:0] m_lut = 16'h0000;
  logic [N:0]  exp_q[$];

  lut_scan #(.N(N)) dut (
    .iClk   (clk),
    .iRstN  (rst_n),
    .iLoad  (load),
    .iBit   (bit_in),
    .iX     (x),
    .iEval  (eval),
    .iStart (start),
    .oY     (y),
    .oValid (valid),
    .oIdx   (idx),
    .oBusy  (busy),
    .oDone  (done)
`ifdef LUT_SCAN_ONES_EN
    ,
    .oOnes  (ones)
`endif
  );

  always #5 clk = ~clk;

  // Result monitor: every oValid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      logic [N:0] e;
      valid_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got y=%0b idx=%0d, required no result", y, idx);
      end else begin
        e = exp_q.pop_front();
        if ({y, idx} !== e) begin
          fails++;
          $display("FAIL result: got y=%0b idx=%0d, required y=%0b idx=%0d",
                   y, idx, e[N], e[N-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load = 0; bit_in = 0; eval = 0; start = 0; x = '0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      load = 1; bit_in = w[k];
      m_lut = {w[k], m_lut[15:1]};
      tick();
    end
    load = 0; bit_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    check_bit("reset_y", y, 1'b0);
    check_bit("reset_valid", valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    tests++;
    if (idx !== '0) begin fails++; $display("FAIL reset_idx: got %0d, required 0", idx); end
`ifdef LUT_SCAN_ONES_EN
    tests++;
    if (ones !== '0) begin fails++; $display("FAIL reset_ones: got %0d, required 0", ones); end
`endif
    rst_n = 1;
    m_lut = 16'h0000;
  endtask

  // Full sweep; optionally hold iLoad=1/iBit=0 while busy to show it is ignored.
  task automatic do_sweep(input string name, input int exp_ones, input bit hold_load);
    valid_count = 0;
    start = 1;
    for (int i = 0; i < 16; i++) exp_q.push_back({m_lut[i], 4'(i)});
    tick();
    start = 0;
    if (hold_load) begin load = 1; bit_in = 0; end
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) check_bit({name, "_busy"}, busy, 1'b1);
      if (c == 17) load = 0;
      check_bit({name, "_done"}, done, (c == 17));
    end
`ifdef LUT_SCAN_ONES_EN
    tests++;
    if (ones !== 5'(exp_ones)) begin
      fails++;
      $display("FAIL %s_ones: got %0d, required %0d", name, ones, exp_ones);
    end
`else
    if (exp_ones < 0) $display("unreachable");
`endif
    @(negedge clk); #1;
    tests++;
    if (valid_count != 16 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_count: got %0d pulses with %0d left, required 16 and 0",
               name, valid_count, exp_q.size());
    end
    tick();
    check_bit({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic test_zero_sweep();
    do_sweep("zero_sweep", 0, 1'b0);
  endtask

  task automatic test_load_eval();
    logic [N-1:0] xs [4];
    xs[0] = 4'd0; xs[1] = 4'd1; xs[2] = 4'd5; xs[3] = 4'd15;
    load_word(16'h8421);
    for (int i = 0; i < 4; i++) begin
      eval = 1; x = xs[i];
      exp_q.push_back({m_lut[xs[i]], xs[i]});
      tick();
    end
    eval = 0;
    tick();
    check_bit("eval_drain", valid, 1'b0);
    check_bit("eval_hold_y", y, 1'b1);
    tests++;
    if (idx !== 4'd15 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL eval_hold_idx: got idx=%0d left=%0d, required idx=15 left=0",
               idx, exp_q.size());
    end
  endtask

  task automatic test_sweep_8421();
    do_sweep("sweep_8421", 4, 1'b0);
  endtask

  task automatic test_all_ones();
    load_word(16'hFFFF);
    do_sweep("ones_sweep", 16, 1'b1);
    do_sweep("ones_rescan", 16, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 0;
    start = 1;
    for (int i = 0; i < 16; i++) exp_q.push_back({m_lut[i], 4'(i)});
    tick();
    start = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (valid && idx == 4'd5) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL mid_sweep_idx5: got none, required idx=5"); end
    rst_n = 0;
    tick();
    exp_q.delete();
    check_bit("mid_reset_busy", busy, 1'b0);
    check_bit("mid_reset_valid", valid, 1'b0);
    check_bit("mid_reset_y", y, 1'b0);
    tests++;
    if (idx !== '0) begin fails++; $display("FAIL mid_reset_idx: got %0d, required 0", idx); end
    rst_n = 1;
    m_lut = 16'h0000;
    // First cycle after reset release must accept an eval; INIT is all zero.
    eval = 1; x = 4'd15;
    exp_q.push_back({1'b0, 4'd15});
    tick();
    eval = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_bit("mid_reset_no_done", done, 1'b0);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL post_reset_eval: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_priority();
    load = 1; bit_in = 1; start = 1; eval = 1; x = 4'd0;
    m_lut = {1'b1, m_lut[15:1]};
    tick();
    clear_inputs();
    check_bit("prio_valid", valid, 1'b0);
    check_bit("prio_busy", busy, 1'b0);
    tick();
    check_bit("prio_still_idle", busy, 1'b0);
    eval = 1; x = 4'd15;
    exp_q.push_back({m_lut[15], 4'd15});
    tick();
    eval = 0;
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL prio_shift: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_sweep();
    test_load_eval();
    test_sweep_8421();
    test_all_ones();
    test_reset_mid_sweep();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lut_scan.md
LUT_SCAN -- requirements
Module: lut_scan

Interface
REQ-001 Parameter N, default 4, SHALL set the number of function inputs; legal range 2..8.
REQ-002 Parameter INIT, default {2**N{1'b0}}, SHALL set the truth table's reset contents; bit k is the output for input vector k.
REQ-003 iClk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 iRstN  input  1  SHALL be the synchronous, active-low reset.
REQ-005 iLoad  input  1  SHALL be the serial truth-table load strobe.
REQ-006 iBit  input  1  SHALL carry the serial load data bit.
REQ-007 iX  input  N  SHALL carry the input vector for single evaluation.
REQ-008 iEval  input  1  SHALL request a single evaluation of iX.
REQ-009 iStart  input  1  SHALL request an exhaustive sweep of the table.
REQ-010 oY  output  1  SHALL carry the registered function result.
REQ-011 oValid  output  1  SHALL be a one-cycle qualifier for oY.
REQ-012 oIdx  output  N  SHALL carry the input vector that produced the current oY.
REQ-013 oBusy  output  1  SHALL be high while the FSM is in SCAN or DONE.
REQ-014 oDone  output  1  SHALL give a one-cycle pulse at the end of a sweep.
REQ-015 oOnes  output  N+1  SHALL carry the minterm count; this port is present only per REQ-032.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, SCAN and DONE, and SHALL hold a 2**N-bit table register named lut.
REQ-017 In IDLE, request priority SHALL be iLoad > iStart > iEval; lower-priority requests in the same cycle SHALL be dropped.
REQ-018 Load in IDLE: lut SHALL become {iBit, lut[2**N-1:1]}; after 2**N loads, the first bit sent SHALL be at index 0.
REQ-019 iLoad, iEval and iStart SHALL be ignored outside IDLE.
REQ-020 Eval in IDLE: on the next cycle, oY SHALL equal lut[iX], oIdx SHALL equal iX and oValid SHALL be 1; latency is 1 cycle, and back-to-back evals SHALL give one result per cycle.
REQ-021 On iStart in IDLE, the FSM SHALL go to SCAN, clear the internal counter idx to 0 and clear oOnes.
REQ-022 On each SCAN cycle: oY SHALL become lut[idx], oIdx SHALL become idx, oValid SHALL become 1, and idx SHALL increment modulo 2**N.
REQ-023 When idx = 2**N-1 in SCAN, the FSM SHALL go to DONE, and idx SHALL wrap to 0.
REQ-024 DONE SHALL last one cycle with oDone=1 and oValid=0, then return to IDLE.
REQ-025 A sweep SHALL produce exactly 2**N consecutive oValid pulses, with oDone one cycle after the last pulse.
REQ-026 oValid and oDone SHALL be 0 in every cycle not covered by REQ-020, REQ-022 or REQ-024.
REQ-027 oY and oIdx SHALL hold their last value when oValid=0.
REQ-028 lut SHALL be unchanged by eval and by scan.

Reset
REQ-029 When iRstN=0 at a clock edge, the state SHALL become IDLE, lut SHALL become INIT, idx SHALL become 0, and oY, oValid, oIdx, oBusy, oDone and oOnes SHALL all become 0.
REQ-030 A reset asserted mid-sweep or mid-load SHALL abort it with no oDone pulse, and all other inputs SHALL be ignored while iRstN=0.
REQ-031 The block SHALL accept requests in the first cycle after iRstN returns to 1.

Configuration
REQ-032 With LUT_SCAN_ONES_EN defined, oOnes SHALL exist and SHALL increment by 1 on each SCAN cycle where lut[idx]=1; its final value SHALL be valid during the DONE cycle and held until the next iStart or reset, with width N+1 so that the all-ones case does not overflow.
REQ-033 Without LUT_SCAN_ONES_EN defined, the oOnes port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then N=4, iStart -> 16 oValid pulses all with oY=0, oDone on cycle 17 after iStart, oOnes=0.
REQ-035 Load 16'h8421 in 16 cycles, then iEval with iX=0,1,5,15 back-to-back -> oY=1,0,1,1 on the four following cycles, with oIdx matching iX.
REQ-036 With 16'h8421 loaded, iStart -> oIdx 0..15 in order, oY=1 exactly at oIdx 0,5,10,15, oOnes=4 at oDone; with the macro absent, the same oY sequence.
REQ-037 Load all ones, iStart -> oOnes=5'd16 at oDone; iLoad=1 with iBit=0 held throughout the sweep -> lut unchanged, and a rescan also gives oOnes=16.
REQ-038 iRstN=0 while oIdx=5 during a sweep -> on the next edge oBusy=0, oValid=0, oY=0, oIdx=0, lut=INIT, and no oDone pulse.
REQ-039 In IDLE, iLoad, iStart and iEval asserted together -> only a shift occurs, the FSM stays in IDLE, and oValid=0 on the next cycle.
